// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants and helpers for the seven-segment readback decoder
package sevenseg_pkg;

  // Active-low cathode patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit slot indices, matching anode bit positions
  localparam logic [1:0] DIG_MIN_TEN = 2'd3;
  localparam logic [1:0] DIG_MIN_ONE = 2'd2;
  localparam logic [1:0] DIG_SEC_TEN = 2'd1;
  localparam logic [1:0] DIG_SEC_ONE = 2'd0;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ANODE_IDLE  = 2'd0,
    ANODE_ONE   = 2'd1,
    ANODE_MULTI = 2'd2
  } anode_kind_e;

  // Classify an active-low anode sample: none, exactly one, or several digits enabled
  function automatic anode_kind_e anode_kind(input logic [3:0] anode);
    case (anode)
      4'b1111:                            return ANODE_IDLE;
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return ANODE_ONE;
      default:                            return ANODE_MULTI;
    endcase
  endfunction

  // Slot index of the single low anode; only meaningful when anode_kind is ANODE_ONE
  function automatic logic [1:0] anode_index(input logic [3:0] anode);
    case (anode)
      4'b0111: return DIG_MIN_TEN;
      4'b1011: return DIG_MIN_ONE;
      4'b1101: return DIG_SEC_TEN;
      default: return DIG_SEC_ONE;
    endcase
  endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational cathode pattern to BCD/blank/error lookup
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] cathode,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  // Anything not in the table is flagged invalid
  always_comb begin
    value = DIGIT_INVALID;
    blank = 1'b0;
    err   = 1'b1;
    case (cathode)
      SEG_0:     begin value = 4'd0; err = 1'b0; end
      SEG_1:     begin value = 4'd1; err = 1'b0; end
      SEG_2:     begin value = 4'd2; err = 1'b0; end
      SEG_3:     begin value = 4'd3; err = 1'b0; end
      SEG_4:     begin value = 4'd4; err = 1'b0; end
      SEG_5:     begin value = 4'd5; err = 1'b0; end
      SEG_6:     begin value = 4'd6; err = 1'b0; end
      SEG_7:     begin value = 4'd7; err = 1'b0; end
      SEG_8:     begin value = 4'd8; err = 1'b0; end
      SEG_9:     begin value = 4'd9; err = 1'b0; end
      SEG_BLANK: begin value = 4'd0; blank = 1'b1; err = 1'b0; end
      default:   begin value = DIGIT_INVALID; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - debounced MM:SS frame capture from a muxed seven-segment bus (optional SEVENSEG_CAPTURE_BLINK_EN)
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int BLINK_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] anode,
  input  logic [6:0] cathode,
  output logic [3:0] min_ten,
  output logic [3:0] min_one,
  output logic [3:0] sec_ten,
  output logic [3:0] sec_one,
  output logic [3:0] blank,
  output logic       frame_valid,
  output logic       pattern_err,
  output logic       multi_err,
  output logic       display_off,
  output logic [3:0] blinking
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [10:0]       samp;
  logic [10:0]       samp_q;
  logic [SW-1:0]     stab_cnt;
  logic              same;
  logic              commit;
  logic              single_commit;
  logic              multi_commit;
  anode_kind_e       kind;
  logic [1:0]        slot_idx;

  logic [3:0]        dec_value;
  logic              dec_blank;
  logic              dec_err;

  logic [3:0][3:0]   slot_val;
  logic [3:0]        slot_blank;
  logic [3:0]        slot_err;
  logic [3:0]        seen;
  logic              frame_done;
  logic [3:0][3:0]   frame_dig;
  logic [TW-1:0]     tcnt;

  assign same       = (samp == samp_q);
  // The run commits exactly on the edge that brings the counter to its terminal value
  assign commit     = same && (stab_cnt == STABLE_MAX - SW'(1));
  assign kind       = anode_kind(samp[10:7]);
  assign slot_idx   = anode_index(samp[10:7]);
  assign single_commit = commit && (kind == ANODE_ONE);
  assign multi_commit  = commit && (kind == ANODE_MULTI);
  assign frame_done = (seen == 4'b1111);

  seg_decode u_decode (
    .cathode (samp[6:0]),
    .value   (dec_value),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  // Register the bus and count how long the registered sample has held still
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      samp     <= '1;
      samp_q   <= '1;
      stab_cnt <= '0;
    end else begin
      samp   <= {anode, cathode};
      samp_q <= samp;
      if (!same)
        stab_cnt <= SW'(1);
      else if (stab_cnt != STABLE_MAX)
        stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // Per-slot staging buffers written by single-anode commits
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_val   <= '0;
      slot_blank <= '0;
      slot_err   <= '0;
    end else if (single_commit) begin
      slot_val[slot_idx]   <= dec_value;
      slot_blank[slot_idx] <= dec_blank;
      slot_err[slot_idx]   <= dec_err;
    end
  end

  // Frame assembly: publish once all four slots are seen; a same-edge commit seeds the next frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seen        <= '0;
      frame_dig   <= '0;
      blank       <= 4'hF;
      pattern_err <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        frame_dig   <= slot_val;
        blank       <= slot_blank;
        pattern_err <= |slot_err;
      end
      seen <= (frame_done ? 4'b0000 : seen) |
              (single_commit ? (4'b0001 << slot_idx) : 4'b0000);
    end
  end

  // Sticky flag for a debounced sample with several digits enabled at once
  always_ff @(posedge clk) begin
    if (!reset_n)
      multi_err <= 1'b0;
    else if (multi_commit)
      multi_err <= 1'b1;
  end

  // Saturating inactivity timer; a single-anode commit beats the terminal count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tcnt        <= '0;
      display_off <= 1'b0;
    end else if (single_commit) begin
      tcnt        <= '0;
      display_off <= 1'b0;
    end else if (tcnt != TIMEOUT_MAX) begin
      tcnt <= tcnt + TW'(1);
      if (tcnt == TIMEOUT_MAX - TW'(1))
        display_off <= 1'b1;
    end
  end

  assign min_ten = frame_dig[DIG_MIN_TEN];
  assign min_one = frame_dig[DIG_MIN_ONE];
  assign sec_ten = frame_dig[DIG_SEC_TEN];
  assign sec_one = frame_dig[DIG_SEC_ONE];

`ifdef SEVENSEG_CAPTURE_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES);

  logic [3:0][BW-1:0] tog_cnt;
  logic [3:0]         blink_q;

  // Count frame-to-frame blank toggles per digit; an unchanged frame clears the digit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tog_cnt <= '0;
      blink_q <= '0;
    end else if (frame_done) begin
      for (int i = 0; i < 4; i++) begin
        if (slot_blank[i] != blank[i]) begin
          if (tog_cnt[i] != BLINK_MAX) begin
            tog_cnt[i] <= tog_cnt[i] + BW'(1);
            if (tog_cnt[i] == BLINK_MAX - BW'(1))
              blink_q[i] <= 1'b1;
          end
        end else begin
          tog_cnt[i] <= '0;
          blink_q[i] <= 1'b0;
        end
      end
    end
  end

  assign blinking = blink_q;
`else
  // Blink detection compiled out; the parameter is still referenced so both builds share one interface
  assign blinking = 4'(BLINK_FRAMES) & 4'b0000;
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - scoreboard bench for sevenseg_capture
module tb_sevenseg_capture;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SX = 7'b0110110;

`ifdef SEVENSEG_CAPTURE_BLINK_EN
  localparam logic [3:0] EXP_BLINK = 4'b1100;
`else
  localparam logic [3:0] EXP_BLINK = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic [3:0] min_ten, min_one, sec_ten, sec_one;
  logic [3:0] blank;
  logic       frame_valid;
  logic       pattern_err;
  logic       multi_err;
  logic       display_off;
  logic [3:0] blinking;

  always #5 clk = ~clk;

  sevenseg_capture #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100),
    .BLINK_FRAMES   (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .anode       (anode),
    .cathode     (cathode),
    .min_ten     (min_ten),
    .min_one     (min_one),
    .sec_ten     (sec_ten),
    .sec_one     (sec_one),
    .blank       (blank),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err),
    .multi_err   (multi_err),
    .display_off (display_off),
    .blinking    (blinking)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  blk;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   frames = 0;
  logic fv_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] dig, input logic [3:0] blk, input logic perr);
    exp_t e;
    e.dig  = dig;
    e.blk  = blk;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] ca, input int n);
    anode   = an;
    cathode = ca;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0);
    hold(4'b0111, p3, 10);
    hold(4'b1011, p2, 10);
    hold(4'b1101, p1, 10);
    hold(4'b1110, p0, 10);
    hold(4'b1111, SB, 10);
  endtask

  // Monitor: every published frame is matched against the oldest expectation
  always @(negedge clk) begin
    if (reset_n && frame_valid) begin
      frames++;
      chk("frame_valid_single_cycle", {31'd0, fv_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_frame: got digits %h%h%h%h, expected no frame", min_ten, min_one, sec_ten, sec_one);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_digits", {16'd0, min_ten, min_one, sec_ten, sec_one}, {16'd0, e.dig});
        chk("frame_blank", {28'd0, blank}, {28'd0, e.blk});
        chk("frame_pattern_err", {31'd0, pattern_err}, {31'd0, e.perr});
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    reset_n = 1'b0;
    anode   = 4'b1111;
    cathode = SB;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_min_ten", {28'd0, min_ten}, 32'd0);
    chk("reset_min_one", {28'd0, min_one}, 32'd0);
    chk("reset_sec_ten", {28'd0, sec_ten}, 32'd0);
    chk("reset_sec_one", {28'd0, sec_one}, 32'd0);
    chk("reset_blank", {28'd0, blank}, 32'hF);
    chk("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("reset_pattern_err", {31'd0, pattern_err}, 32'd0);
    chk("reset_multi_err", {31'd0, multi_err}, 32'd0);
    chk("reset_display_off", {31'd0, display_off}, 32'd0);
    chk("reset_blinking", {28'd0, blinking}, 32'd0);

    // Idle bus: idle commits must not hold off the timeout, which lands on edge 100
    reset_n = 1'b1;
    repeat (99) @(posedge clk);
    #1;
    chk("display_off_edge99", {31'd0, display_off}, 32'd0);
    @(posedge clk);
    #1;
    chk("display_off_edge100", {31'd0, display_off}, 32'd1);

    // Basic frame 12:34, also clears display_off
    push(16'h1234, 4'b0000, 1'b0);
    scan(S1, S2, S3, S4);
    chk("display_off_cleared", {31'd0, display_off}, 32'd0);
    chk("frames_after_scan1", frames, 1);

    // Last slot held one cycle short: no commit, no frame
    hold(4'b0111, S5, 10);
    hold(4'b1011, S6, 10);
    hold(4'b1101, S7, 10);
    hold(4'b1110, S8, 3);
    hold(4'b1111, SB, 10);
    chk("frames_after_short_slot", frames, 1);

    // Two anodes low: sticky multi_err, nothing written
    chk("multi_err_before", {31'd0, multi_err}, 32'd0);
    hold(4'b0110, S8, 10);
    hold(4'b1111, SB, 10);
    chk("multi_err_set", {31'd0, multi_err}, 32'd1);
    chk("frames_after_multi", frames, 1);
    push(16'h0598, 4'b0000, 1'b0);
    scan(S0, S5, S9, S8);
    chk("multi_err_sticky", {31'd0, multi_err}, 32'd1);

    // Blank slot and an undecodable pattern
    push(16'h760F, 4'b0010, 1'b1);
    scan(S7, S6, SB, SX);
    chk("frames_after_err", frames, 3);

    // Blink sequence on the minute digits
    push(16'h1234, 4'b0000, 1'b0);
    scan(S1, S2, S3, S4);
    push(16'h1234, 4'b0000, 1'b0);
    scan(S1, S2, S3, S4);
    chk("blinking_steady", {28'd0, blinking}, 32'd0);
    push(16'h0034, 4'b1100, 1'b0);
    scan(SB, SB, S3, S4);
    chk("blinking_one_toggle", {28'd0, blinking}, 32'd0);
    push(16'h1234, 4'b0000, 1'b0);
    scan(S1, S2, S3, S4);
    chk("blinking_two_toggles", {28'd0, blinking}, {28'd0, EXP_BLINK});
    push(16'h1234, 4'b0000, 1'b0);
    scan(S1, S2, S3, S4);
    chk("blinking_cleared", {28'd0, blinking}, 32'd0);
    chk("frames_after_blink", frames, 8);

    // Timeout after a running display goes dark, next frame clears it
    hold(4'b1111, SB, 110);
    chk("display_off_timeout", {31'd0, display_off}, 32'd1);
    push(16'h9876, 4'b0000, 1'b0);
    scan(S9, S8, S7, S6);
    chk("display_off_recovered", {31'd0, display_off}, 32'd0);
    chk("frames_after_timeout", frames, 9);

    // Reset mid-frame discards partial slots and clears sticky state
    hold(4'b0111, S2, 10);
    hold(4'b1011, S2, 10);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_blank", {28'd0, blank}, 32'hF);
    chk("midreset_min_ten", {28'd0, min_ten}, 32'd0);
    chk("midreset_multi_err", {31'd0, multi_err}, 32'd0);
    reset_n = 1'b1;
    hold(4'b1011, S3, 10);
    hold(4'b1101, S3, 10);
    hold(4'b1110, S3, 10);
    hold(4'b1111, SB, 20);
    chk("frames_after_midreset", frames, 9);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
